// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, sequencer states, funct3 constants.
// Imported by the operand sequencer, its formatter and the ALU itself.
package alu_pkg;

  localparam logic [31:0] SIGN_FLIP = 32'h8000_0000;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SRL  = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC
  } seq_state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_SR   = 3'b101;

  typedef struct packed {
    logic [2:0]  funct3;
    logic        sub;
    logic        use_imm;
    logic [31:0] imm;
    logic        is_branch;
    logic        to_addr;
  } seq_req_t;

endpackage

// File: rtl/alu_operand_seq_if.sv
// Request / completion handshake between decode and the operand sequencer.
// master = decode side, slave = sequencer.
interface alu_operand_seq_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_sub;
  logic        req_use_imm;
  logic [31:0] req_imm;
  logic        req_is_branch;
  logic        req_to_addr;
  logic        done_valid;
  logic        done_err;
  logic        branch_taken;

  modport master (
    output req_valid, req_funct3, req_sub,
    output req_use_imm, req_imm,
    output req_is_branch, req_to_addr,
    input  req_ready, done_valid,
    input  done_err, branch_taken
  );

  modport slave (
    input  req_valid, req_funct3, req_sub,
    input  req_use_imm, req_imm,
    input  req_is_branch, req_to_addr,
    output req_ready, done_valid,
    output done_err, branch_taken
  );

endinterface

// File: rtl/alu_operand_fmt.sv
// Operand formatter: negate for SUB, sign flip for signed
// compares, shift-amount mask, and funct3 -> ALU op mapping.
module alu_operand_fmt
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs_a,
  input  logic [XLEN-1:0] rs_b,
  input  logic [2:0]      funct3,
  input  logic            sub,
  input  logic            use_imm,
  input  logic            is_branch,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output alu_op_t         op
);

  logic signed_cmp;
  logic negate;
  logic shift;

  always_comb begin
    signed_cmp = is_branch
      ? (funct3 == F3_BLT || funct3 == F3_BGE)
      : (funct3 == F3_SLT);
    negate = !is_branch && funct3 == F3_ADD
      && sub && !use_imm;
    shift = !is_branch
      && (funct3 == F3_SLL || funct3 == F3_SR);
  end

  // the ALU compares unsigned only; flipping both sign
  // bits turns that into a signed compare
  always_comb begin
    a = signed_cmp ? (rs_a ^ SIGN_FLIP) : rs_a;
    b = rs_b;
    unique case (1'b1)
      negate:     b = ~rs_b + 32'd1;
      shift:      b = rs_b & 32'd31;
      signed_cmp: b = rs_b ^ SIGN_FLIP;
      default:    b = rs_b;
    endcase
  end

  always_comb begin
    op = ALU_ADD;
    if (is_branch) begin
      op = ALU_SLTU;
    end else begin
      case (funct3)
        3'b000:  op = ALU_ADD;
        3'b001:  op = ALU_SLL;
        3'b010:  op = ALU_SLTU;
        3'b011:  op = ALU_SLTU;
        3'b100:  op = ALU_XOR;
        3'b101:  op = ALU_SRL;
        3'b110:  op = ALU_OR;
        default: op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_seq.sv
// ALU operand sequencer: fetch rs1/rs2 or imm, format, execute.
// ALU_SEQ_BRANCH_EN enables branch evaluation; otherwise branches error.
module alu_operand_seq
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit IMM_FAST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_operand_seq_if.slave  sif,
  input  logic [XLEN-1:0]   bus_in,
  output logic              rf_rd_en,
  output logic              rf_rd_sel,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output alu_op_t           alu_op,
  output logic              alu_bus_en,
  output logic              alu_addr_en,
  input  logic              alu_eq,
  input  logic              alu_lt,
  input  logic              alu_ge
);

  seq_state_t state, state_nx;
  seq_req_t   q;

  logic            accept;
  logic            fast_imm;
  logic            exec;
  logic            err;
  logic            br_err;
  logic            cond;
  logic [XLEN-1:0] fmt_a;
  logic [XLEN-1:0] fmt_b;
  alu_op_t         fmt_op;

  assign accept   = sif.req_valid && sif.req_ready;
  assign fast_imm = IMM_FAST && q.use_imm;
  assign exec     = (state == S_EXEC);

  alu_operand_fmt #(.XLEN(XLEN)) u_fmt (
    .rs_a      (bus_in),
    .rs_b      (q.use_imm ? q.imm : bus_in),
    .funct3    (q.funct3),
    .sub       (q.sub),
    .use_imm   (q.use_imm),
    .is_branch (q.is_branch),
    .a         (fmt_a),
    .b         (fmt_b),
    .op        (fmt_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (sif.req_valid) state_nx = S_LOAD_A;
      S_LOAD_A: state_nx = fast_imm ? S_EXEC : S_LOAD_B;
      S_LOAD_B: state_nx = S_EXEC;
      S_EXEC:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= ALU_ADD;
    end else begin
      if (accept) begin
        q.funct3    <= sif.req_funct3;
        q.sub       <= sif.req_sub;
        q.use_imm   <= sif.req_use_imm;
        q.imm       <= sif.req_imm;
        q.is_branch <= sif.req_is_branch;
        q.to_addr   <= sif.req_to_addr;
      end
      if (state == S_LOAD_A) begin
        alu_a  <= fmt_a;
        alu_op <= fmt_op;
      end
      if ((state == S_LOAD_A && fast_imm)
          || state == S_LOAD_B)
        alu_b <= fmt_b;
    end
  end

`ifdef ALU_SEQ_BRANCH_EN
  assign br_err = q.is_branch
    && (q.funct3 == F3_SLT || q.funct3 == F3_SLTU);

  always_comb begin
    cond = 1'b0;
    unique case (1'b1)
      q.funct3 == F3_BEQ: cond = alu_eq;
      q.funct3 == F3_BNE: cond = !alu_eq;
      q.funct3 == F3_BLT
        || q.funct3 == F3_BLTU: cond = alu_lt;
      q.funct3 == F3_BGE
        || q.funct3 == F3_BGEU: cond = alu_ge;
      default: cond = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = ^{alu_eq, alu_lt, alu_ge};
  assign br_err = q.is_branch;
  assign cond   = 1'b0;
`endif

  // SRA/SRAI has no ALU support
  assign err = br_err || (!q.is_branch
    && q.funct3 == F3_SR && q.sub);

  assign sif.req_ready    = (state == S_IDLE);
  assign sif.done_valid   = exec;
  assign sif.done_err     = exec && err;
  assign sif.branch_taken = exec && q.is_branch
    && !err && cond;

  assign rf_rd_en  = (state == S_LOAD_A)
    || (state == S_LOAD_B && !q.use_imm);
  assign rf_rd_sel = (state == S_LOAD_B) && !q.use_imm;

  assign alu_bus_en  = exec && !err
    && !q.is_branch && !q.to_addr;
  assign alu_addr_en = exec && !err
    && !q.is_branch && q.to_addr;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Randomized bench for alu_operand_seq (IMM_FAST=1 and =0 side by side)
// against a spec-level reference model.
module tb_alu_operand_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  alu_operand_seq_if f0 ();
  alu_operand_seq_if f1 ();

  logic [31:0] rs1_v, rs2_v;
  logic [31:0] bus0, bus1, a0, b0, a1, b1;
  logic rd0, sel0, rd1, sel1;
  logic ben0, aen0, ben1, aen1;
  logic eq0, lt0, ge0, eq1, lt1, ge1;
  alu_op_t op0, op1;

  logic [2:0]  t_f3;
  logic        t_sub, t_uimm, t_br, t_addr;
  logic [31:0] t_imm;
  logic        v0 = 1'b0;
  logic        v1 = 1'b0;

  assign f0.req_valid     = v0;
  assign f0.req_funct3    = t_f3;
  assign f0.req_sub       = t_sub;
  assign f0.req_use_imm   = t_uimm;
  assign f0.req_imm       = t_imm;
  assign f0.req_is_branch = t_br;
  assign f0.req_to_addr   = t_addr;
  assign f1.req_valid     = v1;
  assign f1.req_funct3    = t_f3;
  assign f1.req_sub       = t_sub;
  assign f1.req_use_imm   = t_uimm;
  assign f1.req_imm       = t_imm;
  assign f1.req_is_branch = t_br;
  assign f1.req_to_addr   = t_addr;

  // register file on the bus; junk when not selected
  assign bus0 = rd0 ? (sel0 ? rs2_v : rs1_v) : 32'hDEAD_BEEF;
  assign bus1 = rd1 ? (sel1 ? rs2_v : rs1_v) : 32'hDEAD_BEEF;
  // unsigned-compare ALU
  assign eq0 = (a0 == b0);
  assign lt0 = (a0 < b0);
  assign ge0 = (a0 >= b0);
  assign eq1 = (a1 == b1);
  assign lt1 = (a1 < b1);
  assign ge1 = (a1 >= b1);

  alu_operand_seq #(.XLEN(32), .IMM_FAST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .sif(f0.slave),
    .bus_in(bus0), .rf_rd_en(rd0), .rf_rd_sel(sel0),
    .alu_a(a0), .alu_b(b0), .alu_op(op0),
    .alu_bus_en(ben0), .alu_addr_en(aen0),
    .alu_eq(eq0), .alu_lt(lt0), .alu_ge(ge0)
  );

  alu_operand_seq #(.XLEN(32), .IMM_FAST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .sif(f1.slave),
    .bus_in(bus1), .rf_rd_en(rd1), .rf_rd_sel(sel1),
    .alu_a(a1), .alu_b(b1), .alu_op(op1),
    .alu_bus_en(ben1), .alu_addr_en(aen1),
    .alu_eq(eq1), .alu_lt(lt1), .alu_ge(ge1)
  );

`ifdef ALU_SEQ_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] e_a, e_b, e_op;
  logic e_err, e_tk, e_ben, e_aen;

  task automatic model(input logic [2:0] f3,
                       input logic sub, uimm,
                       input logic [31:0] imm,
                       input logic br, to_addr,
                       input logic [31:0] r1, r2);
    logic [31:0] bv;
    logic sc;
    int unsigned op_tab [8] = '{0, 1, 3, 3, 4, 5, 6, 7};
    bv = uimm ? imm : r2;
    e_err = br ? (!BR_EN || f3 == 3'd2 || f3 == 3'd3)
               : (f3 == 3'd5 && sub);
    sc = br ? (f3 == 3'd4 || f3 == 3'd5) : (f3 == 3'd2);
    e_a = sc ? r1 + 32'h8000_0000 : r1;
    if (!br && f3 == 3'd0 && sub && !uimm)
      e_b = 32'd0 - bv;
    else if (!br && (f3 == 3'd1 || f3 == 3'd5))
      e_b = bv % 32;
    else if (sc)
      e_b = bv + 32'h8000_0000;
    else
      e_b = bv;
    e_op = br ? 32'd3 : op_tab[f3];
    e_tk = 1'b0;
    if (br && !e_err) begin
      case (f3)
        3'd0: e_tk = (r1 == bv);
        3'd1: e_tk = (r1 != bv);
        3'd4: e_tk = ($signed(r1) < $signed(bv));
        3'd5: e_tk = ($signed(r1) >= $signed(bv));
        3'd6: e_tk = (r1 < bv);
        default: e_tk = (r1 >= bv);
      endcase
    end
    e_ben = !e_err && !br && !to_addr;
    e_aen = !e_err && !br && to_addr;
  endtask

  task automatic run(input string tag,
                     input logic [2:0] f3,
                     input logic sub, uimm,
                     input logic [31:0] imm,
                     input logic br, to_addr,
                     input logic [31:0] r1, r2);
    int edges;
    int lat [2];
    int np [2];
    logic [31:0] s_a [2];
    logic [31:0] s_b [2];
    logic [31:0] s_op [2];
    logic s_err [2];
    logic s_tk [2];
    logic s_ben [2];
    logic s_aen [2];
    model(f3, sub, uimm, imm, br, to_addr, r1, r2);
    @(negedge clk);
    t_f3 = f3; t_sub = sub; t_uimm = uimm; t_imm = imm;
    t_br = br; t_addr = to_addr;
    rs1_v = r1; rs2_v = r2;
    check({tag, ".ready"},
          32'(f0.req_ready && f1.req_ready), 32'd1);
    v0 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    // request fields must not matter after accept
    t_f3 = 3'($urandom); t_sub = 1'($urandom);
    t_uimm = 1'($urandom); t_imm = $urandom;
    t_br = 1'($urandom); t_addr = 1'($urandom);
    edges = 1;
    lat = '{0, 0};
    np = '{0, 0};
    repeat (6) begin
      @(negedge clk);
      if (f0.done_valid) begin
        np[0]++;
        if (lat[0] == 0) begin
          lat[0] = edges; s_a[0] = a0; s_b[0] = b0;
          s_op[0] = 32'(op0); s_err[0] = f0.done_err;
          s_tk[0] = f0.branch_taken;
          s_ben[0] = ben0; s_aen[0] = aen0;
        end
      end
      if (f1.done_valid) begin
        np[1]++;
        if (lat[1] == 0) begin
          lat[1] = edges; s_a[1] = a1; s_b[1] = b1;
          s_op[1] = 32'(op1); s_err[1] = f1.done_err;
          s_tk[1] = f1.branch_taken;
          s_ben[1] = ben1; s_aen[1] = aen1;
        end
      end
      @(posedge clk);
      edges++;
    end
    for (int d = 0; d < 2; d++) begin
      string p;
      int el;
      p = $sformatf("%s.d%0d", tag, d);
      el = (d == 0 && uimm) ? 2 : 3;
      check({p, ".lat"}, 32'(lat[d]), 32'(el));
      check({p, ".pulses"}, 32'(np[d]), 32'd1);
      if (lat[d] != 0) begin
        check({p, ".err"}, 32'(s_err[d]), 32'(e_err));
        check({p, ".taken"}, 32'(s_tk[d]), 32'(e_tk));
        check({p, ".bus_en"}, 32'(s_ben[d]), 32'(e_ben));
        check({p, ".addr_en"}, 32'(s_aen[d]), 32'(e_aen));
        if (!e_err) begin
          check({p, ".a"}, s_a[d], e_a);
          check({p, ".b"}, s_b[d], e_b);
          check({p, ".op"}, s_op[d], e_op);
        end
      end
    end
  endtask

  initial begin
    int np;
    t_f3 = '0; t_sub = 0; t_uimm = 0; t_imm = '0;
    t_br = 0; t_addr = 0; rs1_v = '0; rs2_v = '0;
    repeat (3) @(negedge clk);
    check("rst.ready", 32'(f0.req_ready), 32'd1);
    check("rst.done", 32'(f0.done_valid || f1.done_valid), 32'd0);
    check("rst.a", a0, 32'd0);
    check("rst.b", b0, 32'd0);
    check("rst.op", 32'(op0), 32'd0);
    check("rst.outs", 32'({rd0, sel0, ben0, aen0,
          f0.done_err, f0.branch_taken}), 32'd0);
    rst_n = 1'b1;

    run("add", 3'd0, 0, 0, 32'd0, 0, 0, 32'd5, 32'd7);
    run("sub", 3'd0, 1, 0, 32'd0, 0, 1, 32'd3, 32'd5);
    run("slti", 3'd2, 0, 1, 32'd1, 0, 0,
        32'hFFFF_FFFF, 32'd9);
    run("blt", 3'd4, 0, 0, 32'd0, 1, 0,
        32'hFFFF_FFFE, 32'd1);
    run("bgeu", 3'd7, 0, 0, 32'd0, 1, 0,
        32'hFFFF_FFFE, 32'd1);
    run("sra", 3'd5, 1, 0, 32'd0, 0, 0,
        32'h8000_0000, 32'd4);
    run("sll", 3'd1, 0, 0, 32'd0, 0, 1,
        32'd1, 32'h0000_0125);

    // reset in the middle of a request
    @(negedge clk);
    t_f3 = 3'd0; t_sub = 0; t_uimm = 0; t_br = 0;
    t_addr = 0; rs1_v = 32'd11; rs2_v = 32'd22;
    v0 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid.loadb", 32'({rd0, sel0}), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid.ready", 32'(f0.req_ready && f1.req_ready), 32'd1);
    check("mid.a", a0, 32'd0);
    check("mid.outs", 32'({rd0, sel0, rd1, sel1,
          f0.done_valid, f1.done_valid}), 32'd0);
    np = 0;
    repeat (3) begin
      @(negedge clk);
      if (f0.done_valid || f1.done_valid) np++;
    end
    check("mid.nodone", 32'(np), 32'd0);
    rst_n = 1'b1;
    run("after_rst", 3'd0, 0, 0, 32'd0, 0, 1,
        32'd100, 32'd23);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] r1, r2;
      r1 = ($urandom_range(0, 3) == 0)
        ? 32'($urandom_range(0, 4)) : $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      run($sformatf("rnd%0d", i),
          3'($urandom_range(0, 7)),
          1'($urandom), 1'($urandom),
          ($urandom_range(0, 1) == 0) ? r2 : $urandom,
          ($urandom_range(0, 2) == 0),
          1'($urandom), r1, r2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
